seq_detect_n: RTL and testbench
===============================

Name: seq_detect_n

Overview:
- Parametrised serial sequence recogniser; successor to the fixed 2-bit-state serial FSMs in the exercise set.
- Watches a 1-bit stream qualified by en. Flags every occurrence of a runtime-loaded LEN-bit pattern, with per-bit don't-care mask and selectable overlapping or non-overlapping detection.
- Keeps a saturating match count and a sticky "seen" flag.
- Sits between a serial front end (UART/shift input) and control logic.

Parameters:
- LEN, 4, pattern length in bits (2..32).
- CW, 8, match counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  arm/re-arm: clears history and count, latches pattern/mask/overlap
- en  in  1  serial bit valid
- a  in  1  serial data bit
- pattern  in  LEN  target sequence; pattern[LEN-1] = oldest bit, pattern[0] = newest
- mask  in  LEN  1 = compare bit, 0 = don't care
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- match  out  1  one-cycle pulse, registered
- count  out  CW  saturating number of matches since start
- seen  out  1  sticky; set on first match since start
- armed  out  1  high in FILL or HUNT

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset (synchronous, on posedge clk): state = IDLE; window, fill count, latched pattern/mask/overlap, match, count, seen, armed all 0.
- States:
  - IDLE: en/a ignored; start -> FILL.
  - FILL: fewer than LEN bits in window.
  - HUNT: window holds LEN bits.
- Priority: reset > start > en.
- start (any state, including mid-stream):
  - window <= 0, fill <= 0, count <= 0, seen <= 0, match <= 0.
  - Latch pattern, mask, overlap.
  - Go to FILL.
  - A coincident en bit is discarded.
- Latched pattern/mask/overlap are used until the next start. Changes on the inputs meanwhile have no effect.
- Accepted bit: en=1 in FILL/HUNT, no start.
  - Candidate window w' = {window[LEN-2:0], a}.
  - fill' = min(fill+1, LEN).
  - en=0: no state change; match <= 0.
- Hit: fill' == LEN and ((w' ^ pat) & msk) == 0.
  - Registered: match = 1 in the cycle after the accepting edge, for exactly one cycle.
  - count <= count+1, saturating at 2^CW-1 (holds, no wrap).
  - seen <= 1.
- After a hit:
  - overlap=1: window <= w', fill = LEN, stay in HUNT.
  - overlap=0: window <= 0, fill <= 0, go to FILL. The next hit needs LEN fresh bits.
- No hit: window <= w'; FILL -> HUNT when fill' == LEN.
- mask = 0: every accepted bit with a full window is a hit.
- armed = (state != IDLE), registered with state.
- count and seen hold their values while en is low.

Decomposition:
- Package seq_detect_pkg:
  - statetype enum logic [1:0] {IDLE, FILL, HUNT}.
  - Fill-counter width function clog2(LEN+1).
- Sub-module sat_counter #(W):
  - Ports: clk, reset, clr, inc, q.
  - Increments on inc, saturates at all-ones; clr has priority.
  - Used for count.

Test Plan:
- reset, start with pattern=1011, mask=1111, overlap=1; stream 1,0,1,1,0,1,1 with en=1 -> match pulses after bits 4 and 7; count=2; seen=1.
- Same stream, overlap=0 -> single match after bit 4; count=1; state back in FILL after bit 7 (fill=3).
- pattern=1001, mask=1001, stream 1,1,1,1 -> match after bit 4; stream 0,1,1,1 -> no match.
- en toggled low between every bit of 1011 -> same single match; no shift while en=0; match one cycle wide.
- CW=2, pattern=11, overlap=1, stream of seven 1s -> six hits; count sticks at 3 from the third hit on.
- start asserted with en=1 mid-FILL, new pattern=0000 -> bit discarded, count=0, seen=0; match only after four further 0 bits. reset mid-HUNT -> IDLE, armed=0, en stream ignored until start.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the serial sequence recogniser.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2
  } statetype;

  // Width needed to hold a fill count of 0..len inclusive.
  function automatic int unsigned fill_width(input int unsigned len);
    return unsigned'($clog2(len + 1));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/seq_detect_n.sv
// Serial recogniser for a runtime-loaded LEN-bit pattern with per-bit don't-care mask,
// overlapping or non-overlapping detection, saturating match count and sticky seen flag.
module seq_detect_n
  import seq_detect_pkg::*;
#(
  parameter int unsigned LEN = 4,
  parameter int unsigned CW  = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           en,
  input  logic           a,
  input  logic [LEN-1:0] pattern,
  input  logic [LEN-1:0] mask,
  input  logic           overlap,
  output logic           match,
  output logic [CW-1:0]  count,
  output logic           seen,
  output logic           armed
);

  localparam int unsigned FW = fill_width(LEN);
  localparam logic [FW-1:0] FillFull = FW'(LEN);

  statetype       state_q, state_d;
  logic [LEN-1:0] window_q, window_d;
  logic [FW-1:0]  fill_q, fill_d;
  logic [LEN-1:0] pat_q, pat_d;
  logic [LEN-1:0] msk_q, msk_d;
  logic           ovl_q, ovl_d;
  logic           match_q, match_d;
  logic           seen_q, seen_d;
  logic           armed_q, armed_d;

  logic           accept;
  logic           hit;
  logic [LEN-1:0] w_cand;
  logic [FW-1:0]  fill_nxt;

  assign accept   = en && !start && (state_q != IDLE);
  assign w_cand   = {window_q[LEN-2:0], a};
  assign fill_nxt = (fill_q == FillFull) ? FillFull : fill_q + FW'(1);
  assign hit      = accept && (fill_nxt == FillFull) && (((w_cand ^ pat_q) & msk_q) == '0);

  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    fill_d   = fill_q;
    pat_d    = pat_q;
    msk_d    = msk_q;
    ovl_d    = ovl_q;
    match_d  = 1'b0;
    seen_d   = seen_q;

    if (start) begin
      // Re-arm discards history and any coincident serial bit.
      state_d  = FILL;
      window_d = '0;
      fill_d   = '0;
      seen_d   = 1'b0;
      pat_d    = pattern;
      msk_d    = mask;
      ovl_d    = overlap;
    end else if (accept) begin
      if (hit) begin
        match_d = 1'b1;
        seen_d  = 1'b1;
        if (ovl_q) begin
          window_d = w_cand;
          fill_d   = FillFull;
          state_d  = HUNT;
        end else begin
          window_d = '0;
          fill_d   = '0;
          state_d  = FILL;
        end
      end else begin
        window_d = w_cand;
        fill_d   = fill_nxt;
        state_d  = (fill_nxt == FillFull) ? HUNT : FILL;
      end
    end

    armed_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      window_q <= '0;
      fill_q   <= '0;
      pat_q    <= '0;
      msk_q    <= '0;
      ovl_q    <= 1'b0;
      match_q  <= 1'b0;
      seen_q   <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      fill_q   <= fill_d;
      pat_q    <= pat_d;
      msk_q    <= msk_d;
      ovl_q    <= ovl_d;
      match_q  <= match_d;
      seen_q   <= seen_d;
      armed_q  <= armed_d;
    end
  end

  sat_counter #(
    .W(CW)
  ) u_count (
    .clk  (clk),
    .reset(reset),
    .clr  (start),
    .inc  (hit),
    .q    (count)
  );

  assign match = match_q;
  assign seen  = seen_q;
  assign armed = armed_q;

endmodule

// File: tb/tb_seq_detect_n.sv
// Scoreboarded bench: driver pushes model expectations per clock, monitor pops and compares.
module tb_seq_detect_n;

  localparam int unsigned LEN = 4;
  localparam int unsigned CW  = 3;
  localparam int          CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           en = 1'b0;
  logic           a = 1'b0;
  logic [LEN-1:0] pattern = '0;
  logic [LEN-1:0] mask = '0;
  logic           overlap = 1'b0;
  logic           match;
  logic [CW-1:0]  count;
  logic           seen;
  logic           armed;

  seq_detect_n #(
    .LEN(LEN),
    .CW (CW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .en     (en),
    .a      (a),
    .pattern(pattern),
    .mask   (mask),
    .overlap(overlap),
    .match  (match),
    .count  (count),
    .seen   (seen),
    .armed  (armed)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit match;
    int count;
    bit seen;
    bit armed;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  // Reference model: history of accepted bits since the last start or consumed hit.
  bit             m_armed = 0;
  bit             m_hist[$];
  int             m_count = 0;
  bit             m_seen = 0;
  bit [LEN-1:0]   m_pat = '0;
  bit [LEN-1:0]   m_msk = '0;
  bit             m_ovl = 0;

  task automatic model_update(output bit mt);
    bit ok;
    mt = 0;
    if (reset) begin
      m_armed = 0; m_hist.delete(); m_count = 0; m_seen = 0;
      m_pat = '0; m_msk = '0; m_ovl = 0;
    end else if (start) begin
      m_armed = 1; m_hist.delete(); m_count = 0; m_seen = 0;
      m_pat = pattern; m_msk = mask; m_ovl = overlap;
    end else if (en && m_armed) begin
      m_hist.push_back(a);
      if (m_hist.size() > LEN) void'(m_hist.pop_front());
      if (m_hist.size() == LEN) begin
        ok = 1;
        // m_hist[0] is the oldest bit and lines up with pattern[LEN-1].
        for (int k = 0; k < LEN; k++)
          if (m_msk[LEN-1-k] && (m_hist[k] != m_pat[LEN-1-k])) ok = 0;
        if (ok) begin
          mt = 1;
          m_seen = 1;
          if (m_count < CMAX) m_count++;
          if (!m_ovl) m_hist.delete();
        end
      end
    end
  endtask

  task automatic step(input bit rst, input bit st, input bit e, input bit b,
                      input bit [LEN-1:0] p, input bit [LEN-1:0] m, input bit o);
    exp_t x;
    bit   mt;
    @(negedge clk);
    #1;
    reset = rst; start = st; en = e; a = b; pattern = p; mask = m; overlap = o;
    @(posedge clk);
    cyc++;
    model_update(mt);
    x.match = mt; x.count = m_count; x.seen = m_seen; x.armed = m_armed; x.cyc = cyc;
    exp_q.push_back(x);
  endtask

  task automatic check(input string name, input int got, input int want, input int c);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, c, got, want);
    end
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("match", int'(match), int'(x.match), x.cyc);
        check("count", int'(count), x.count, x.cyc);
        check("seen",  int'(seen),  int'(x.seen), x.cyc);
        check("armed", int'(armed), int'(x.armed), x.cyc);
      end
    end
  end

  task automatic stream(input bit [31:0] bits, input int n, input bit gap);
    for (int i = n - 1; i >= 0; i--) begin
      step(0, 0, 1, bits[i], '0, '0, 0);
      if (gap) step(0, 0, 0, ~bits[i], '0, '0, 0);
    end
  endtask

  initial begin
    bit [LEN-1:0] p, m;
    step(1, 0, 0, 0, '0, '0, 0);
    step(1, 0, 1, 1, '0, '0, 0);
    // Overlapping 1011 over 1011011.
    step(0, 1, 0, 0, 4'b1011, 4'b1111, 1);
    stream(32'b1011011, 7, 0);
    step(0, 0, 0, 0, '0, '0, 0);
    // Non-overlapping, same stream.
    step(0, 1, 0, 0, 4'b1011, 4'b1111, 0);
    stream(32'b1011011, 7, 0);
    step(0, 0, 1, 1, '0, '0, 0);
    // Don't-care bits in the middle.
    step(0, 1, 0, 0, 4'b1001, 4'b1001, 1);
    stream(32'b1111, 4, 0);
    step(0, 1, 0, 0, 4'b1001, 4'b1001, 1);
    stream(32'b0111, 4, 0);
    // en gaps between every bit.
    step(0, 1, 0, 0, 4'b1011, 4'b1111, 1);
    stream(32'b1011, 4, 1);
    // Saturation: effective 2-bit pattern 11, many 1s.
    step(0, 1, 0, 0, 4'b0011, 4'b0011, 1);
    stream(32'h3FFF, 14, 0);
    // All don't-care: every full-window bit hits.
    step(0, 1, 0, 0, 4'b0000, 4'b0000, 1);
    stream(32'b01101, 5, 0);
    // Re-arm mid-FILL with a coincident bit that must be discarded.
    step(0, 1, 0, 0, 4'b1011, 4'b1111, 1);
    stream(32'b10, 2, 0);
    step(0, 1, 1, 0, 4'b0000, 4'b1111, 1);
    stream(32'b0000, 4, 0);
    // Reset mid-HUNT; stream ignored until start.
    step(1, 0, 1, 0, '0, '0, 0);
    stream(32'b00000000, 8, 0);
    step(0, 1, 0, 0, 4'b0000, 4'b1111, 0);
    stream(32'b00000000, 8, 0);
    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      p = LEN'($urandom);
      m = LEN'($urandom) & LEN'($urandom);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) < 7), 1'($urandom), p, m, 1'($urandom));
    end
    step(0, 0, 0, 0, '0, '0, 0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d expected=0 pending", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
